// File: rtl/gpio_debounce_if.sv
// Pad-side bundle for the GPIO debounce filter: configuration and raw pads in,
// debounced levels, change pulses and sample tick out.
interface gpio_debounce_if #(
  parameter int GPIO_PINS = 32,
  parameter int PRESC_W   = 16,
  parameter int CNT_W     = 4
);
  logic                 en;
  logic [PRESC_W-1:0]   presc;
  logic [CNT_W-1:0]     thresh;
  logic [GPIO_PINS-1:0] pad_i;
  logic [GPIO_PINS-1:0] gpio_db_o;
  logic [GPIO_PINS-1:0] chg_o;
  logic                 tick_o;

  modport master (
    output en, presc, thresh, pad_i,
    input  gpio_db_o, chg_o, tick_o
  );

  modport slave (
    input  en, presc, thresh, pad_i,
    output gpio_db_o, chg_o, tick_o
  );
endinterface

// File: rtl/gpio_debounce.sv
// Per-pin GPIO debounce: 2-flop synchroniser, shared sample-tick prescaler and
// per-pin stability counters. GPIO_PINS is expected to be a multiple of 8.
module gpio_debounce #(
  parameter int GPIO_PINS = 32,
  parameter int PRESC_W   = 16,
  parameter int CNT_W     = 4
) (
  input  logic           pclk,
  input  logic           prst,
  gpio_debounce_if.slave bus
);

  logic [GPIO_PINS-1:0] sync1_q;
  logic [GPIO_PINS-1:0] sync2_q;
  logic [GPIO_PINS-1:0] db_q;
  logic [GPIO_PINS-1:0] db_d;
  logic [GPIO_PINS-1:0] chg_q;
  logic [PRESC_W-1:0]   pcnt_q;
  logic [PRESC_W-1:0]   pcnt_d;
  logic                 tick;
  logic                 bypass;

  // The >= compare makes a lowered presc fire on the next cycle instead of wrapping.
  assign tick   = bus.en && (pcnt_q >= bus.presc);
  assign bypass = !bus.en || (bus.thresh == '0);
  assign pcnt_d = (tick || !bus.en) ? '0 : pcnt_q + 1'b1;

  for (genvar n = 0; n < GPIO_PINS; n++) begin : g_pin
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             acc_d;

    assign cnt_inc = {1'b0, cnt_q} + 1'b1;

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
      acc_d = db_q[n];
      cnt_d = cnt_q;
      if (bypass) begin
        acc_d = sync2_q[n];
        cnt_d = '0;
      end else if (sync2_q[n] == db_q[n]) begin
        cnt_d = '0;
      end else if (tick) begin
        if (cnt_inc >= {1'b0, bus.thresh}) begin
          acc_d = sync2_q[n];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_inc[CNT_W-1:0];
        end
      end
    end

    // Clearing the count on reset is what discards an interrupted acceptance.
    always_ff @(posedge pclk or posedge prst) begin
      if (prst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
    end

    assign db_d[n] = acc_d;
  end

  // NOTE: sequential state uses non-blocking assignments so sync1->sync2 is a true two-stage pipe.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pcnt_q  <= '0;
      db_q    <= '0;
      chg_q   <= '0;
    end else begin
      sync1_q <= bus.pad_i;
      sync2_q <= sync1_q;
      pcnt_q  <= pcnt_d;
      db_q    <= db_d;
      chg_q   <= db_d ^ db_q;
    end
  end

  assign bus.gpio_db_o = db_q;
  assign bus.chg_o     = chg_q;
  assign bus.tick_o    = tick && !prst;

endmodule

// File: tb/tb_gpio_debounce.sv
// Directed bench for gpio_debounce: stimulus pushes expected change events into
// a scoreboard queue, a negedge monitor pops one per chg_o pulse and compares.
module tb_gpio_debounce;
  localparam int GPIO_PINS = 32;
  localparam int PRESC_W   = 16;
  localparam int CNT_W     = 4;

  typedef struct {
    int          cyc;
    logic [31:0] db;
    logic [31:0] chg;
  } ev_t;

  logic pclk = 1'b0;
  logic prst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];
  ev_t  ev;
  logic [31:0] exp_db;

  gpio_debounce_if #(.GPIO_PINS(GPIO_PINS), .PRESC_W(PRESC_W), .CNT_W(CNT_W)) bus ();

  gpio_debounce #(.GPIO_PINS(GPIO_PINS), .PRESC_W(PRESC_W), .CNT_W(CNT_W)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic expect_ev(input int at, input logic [31:0] chg);
    sb.push_back('{cyc: at, db: exp_db, chg: chg});
  endtask

  // Monitor: every chg_o pulse must match the oldest expected event.
  always @(negedge pclk) begin
    if (!prst && bus.chg_o != '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_chg: chg_o %h gpio_db_o %h at cycle %0d, none expected",
                 bus.chg_o, bus.gpio_db_o, cyc);
      end else begin
        ev = sb.pop_front();
        check("chg_cycle", cyc, ev.cyc);
        check("gpio_db_o", bus.gpio_db_o, ev.db);
        check("chg_o", bus.chg_o, ev.chg);
      end
    end
  end

  initial begin
    int t;
    int m;
    prst       = 1'b0;
    bus.en     = 1'b1;
    bus.presc  = '0;
    bus.thresh = '0;
    bus.pad_i  = '0;
    exp_db     = '0;
    #1 prst = 1'b1;

    // Reset: outputs cleared, tick suppressed even with en=1 and presc=0.
    step(2);
    check("reset_db", bus.gpio_db_o, 32'h0);
    check("reset_chg", bus.chg_o, 32'h0);
    check("reset_tick", {31'b0, bus.tick_o}, 32'h0);
    prst   = 1'b0;
    bus.en = 1'b0;

    // Bypass: pad[0] rise and fall, 3-edge latency, tick held low.
    step(2);
    t = cyc;
    bus.pad_i[0] = 1'b1;
    exp_db[0] = 1'b1;
    expect_ev(t + 3, 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("tick_en0", {31'b0, bus.tick_o}, 32'h0);
    end
    t = cyc;
    bus.pad_i[0] = 1'b0;
    exp_db[0] = 1'b0;
    expect_ev(t + 3, 32'h1);
    step(8);

    // Filter accept: presc=3, thresh=4, pad[5] held high.
    m = cyc;
    bus.en     = 1'b1;
    bus.presc  = 16'd3;
    bus.thresh = 4'd4;
    bus.pad_i[5] = 1'b1;
    exp_db[5] = 1'b1;
    expect_ev(m + 16, 32'h20);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      check("tick_presc3", {31'b0, bus.tick_o}, {31'b0, ((cyc - m) % 4) == 3});
    end

    // Back to bypass with pad[5] low.
    step(1);
    t = cyc;
    bus.en = 1'b0;
    bus.pad_i[5] = 1'b0;
    exp_db[5] = 1'b0;
    expect_ev(t + 3, 32'h20);
    step(6);

    // Glitch reject: 10-cycle pulse, then a short pulse that must not reuse the old count.
    m = cyc;
    bus.en = 1'b1;
    bus.pad_i[5] = 1'b1;
    step(10);
    bus.pad_i[5] = 1'b0;
    step(14);
    bus.pad_i[5] = 1'b1;
    step(3);
    bus.pad_i[5] = 1'b0;
    step(8);
    check("glitch_db", bus.gpio_db_o, exp_db);

    // Tick every cycle, thresh=1: all pins change together.
    bus.presc  = '0;
    bus.thresh = 4'd1;
    step(3);
    check("tick_presc0", {31'b0, bus.tick_o}, 32'h1);
    t = cyc;
    bus.pad_i = '1;
    exp_db = '1;
    expect_ev(t + 3, 32'hFFFF_FFFF);
    step(6);
    t = cyc;
    bus.pad_i = '0;
    exp_db = '0;
    expect_ev(t + 3, 32'hFFFF_FFFF);
    step(6);

    // Reset mid-count on pad[31], thresh=8: acceptance needs 8 fresh ticks.
    bus.thresh = 4'd8;
    step(1);
    t = cyc;
    bus.pad_i[31] = 1'b1;
    step(5);
    prst = 1'b1;
    #1;
    check("midrst_db", bus.gpio_db_o, 32'h0);
    check("midrst_chg", bus.chg_o, 32'h0);
    check("midrst_tick", {31'b0, bus.tick_o}, 32'h0);
    step(2);
    prst = 1'b0;
    t = cyc;
    exp_db[31] = 1'b1;
    expect_ev(t + 10, 32'h8000_0000);
    step(14);

    // Threshold lowered from 15 to 5 while cnt[2] is 9: accept on the next tick.
    bus.thresh = 4'd15;
    step(1);
    t = cyc;
    bus.pad_i[2] = 1'b1;
    step(11);
    bus.thresh = 4'd5;
    exp_db[2] = 1'b1;
    expect_ev(t + 12, 32'h4);
    step(6);

    // thresh=0 with en=1 is bypass.
    t = cyc;
    bus.thresh = '0;
    bus.pad_i[7] = 1'b1;
    exp_db[7] = 1'b1;
    expect_ev(t + 3, 32'h80);
    step(6);
    check("final_db", bus.gpio_db_o, exp_db);

    check("sb_empty", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_debounce.md
GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

Interface
REQ-001 Parameter GPIO_PINS, default 32, number of pad inputs filtered; SHALL be a multiple of 8.
REQ-002 Parameter PRESC_W, default 16, width of the sample-tick prescaler.
REQ-003 Parameter CNT_W, default 4, width of each per-pin stability counter.
REQ-004 pclk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 prst  input  1  reset, asynchronous, active-high.
REQ-006 en  input  1  1 = debounce filter active; 0 = filter bypassed (synchronised passthrough).
REQ-007 presc  input  PRESC_W  sample tick period minus one, in pclk cycles.
REQ-008 thresh  input  CNT_W  consecutive differing ticks required to accept a new level; 0 = bypass.
REQ-009 pad_i  input  GPIO_PINS  raw asynchronous pad levels.
REQ-010 gpio_db_o  output  GPIO_PINS  debounced levels; connects to the GPIO controller gpio_i.
REQ-011 chg_o  output  GPIO_PINS  per-pin one-cycle pulse when gpio_db_o[n] changes.
REQ-012 tick_o  output  1  one-cycle pulse marking each sample tick.

Function
REQ-013 Every pad_i bit SHALL pass through a 2-flop synchroniser (sync1, sync2) before any other logic; no other path from pad_i exists.
REQ-014 Prescaler: counter pcnt; when en=1 and pcnt>=presc, tick_o=1 for that cycle and pcnt<=0; otherwise pcnt<=pcnt+1.
REQ-015 presc=0 SHALL give tick_o=1 every cycle while en=1; presc lowered below pcnt SHALL cause a tick on the next cycle (>= compare), never a wrap through 2^PRESC_W.
REQ-016 en=0 SHALL hold pcnt at 0 and tick_o at 0.
REQ-017 Bypass (en=0 or thresh=0): gpio_db_o[n]<=sync2[n] every cycle; all per-pin counters <=0.
REQ-018 Bypass latency: pad_i change before edge k SHALL appear on gpio_db_o after edge k+2 (3 edges total).
REQ-019 Filter (en=1, thresh!=0), per pin: if sync2[n]==gpio_db_o[n], cnt[n]<=0 on that cycle regardless of tick.
REQ-020 Filter, per pin: if sync2[n]!=gpio_db_o[n] and tick, cnt[n]<=cnt[n]+1; when cnt[n]+1==thresh, gpio_db_o[n]<=sync2[n] and cnt[n]<=0 instead.
REQ-021 Filter, per pin: if sync2[n]!=gpio_db_o[n] and no tick, cnt[n] SHALL hold.
REQ-022 cnt[n] SHALL never exceed thresh-1 and never wrap; thresh lowered below cnt[n] SHALL accept the level on the next tick (>= compare).
REQ-023 chg_o[n] SHALL be registered, high exactly in the cycle after gpio_db_o[n] changes (coincident with the new value), else 0.
REQ-024 Switching en or thresh between bypass and filter mid-operation SHALL NOT glitch gpio_db_o: the output updates only per REQ-017 or REQ-020 rules from that cycle on.
REQ-025 Pins SHALL be fully independent; simultaneous acceptance on multiple pins in one cycle SHALL raise all corresponding chg_o bits in the same cycle.

Reset
REQ-026 prst=1 SHALL asynchronously clear sync1, sync2, pcnt, all cnt[n], gpio_db_o, chg_o and tick_o to 0.
REQ-027 After prst deasserts, a pad held high SHALL be accepted through the normal filter/bypass path and SHALL produce a chg_o pulse.
REQ-028 prst asserted mid-count SHALL discard the partial count; no gpio_db_o change is produced by the interrupted count.

Verification
REQ-029 Bypass: en=0, pad_i[0] 0->1 before edge 10 -> gpio_db_o[0]=1 after edge 12, chg_o[0]=1 for exactly one cycle after edge 12.
REQ-030 Filter accept: en=1, presc=3, thresh=4, pad_i[5] 0->1 held -> tick_o every 4th cycle; gpio_db_o[5] rises on the 4th tick after sync2[5] goes high; one chg_o[5] pulse.
REQ-031 Glitch reject: en=1, presc=3, thresh=4, pad_i[5] high for 10 cycles then low -> gpio_db_o[5] stays 0, chg_o[5] never asserts, cnt[5] returns to 0.
REQ-032 Tick-every-cycle: presc=0, thresh=1, pad_i=0xFFFF_FFFF -> gpio_db_o=0xFFFF_FFFF 3 edges after the change, all chg_o bits pulse together.
REQ-033 Reset mid-count: presc=0, thresh=8, pad_i[31]=1 for 5 cycles then prst pulsed -> all outputs 0 immediately; after release, acceptance requires 8 fresh ticks.
REQ-034 Threshold change: presc=0, thresh=15, cnt[2] reaches 9, thresh written to 5 -> gpio_db_o[2] updates on the next tick.
